// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// State encoding is fixed so that the values seen in waveforms stay stable.
package serial_subtractor_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle for serial_subtractor.
// The requester drives the master modport and the subtractor uses the slave modport.
interface serial_subtractor_if
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: diff = num1 - num2 - bin, with borrow out.
// This cell is purely combinational.
module full_subtractor (
    input  logic num1,
    input  logic num2,
    input  logic bin,
    output logic diff,
    output logic bout
);
    assign diff = num1 ^ num2 ^ bin;
    assign bout = (~num1 & num2) | (~(num1 ^ num2) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: a single full_subtractor cell is fed LSB-first.
// It takes one bit per clock and presents the result after WIDTH RUN cycles.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_subtractor_if.slave   bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam int RES_W = (WIDTH > 1) ? WIDTH - 1 : 1;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   sa_q, sa_d;
    logic [WIDTH-1:0]   sb_q, sb_d;
    logic [RES_W-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
    logic               bout_q, bout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               cell_diff;
    logic               cell_bout;
    logic [RES_W-1:0]   res_shift;
    logic [WIDTH-1:0]   res_full;
    logic               accept;

    full_subtractor u_cell (
        .num1 (sa_q[0]),
        .num2 (sb_q[0]),
        .bin  (borrow_q),
        .diff (cell_diff),
        .bout (cell_bout)
    );

    // The final MSB goes straight into diff, so only WIDTH-1 partial bits are stored.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_full  = cell_diff;
            assign res_shift = 1'b0;
        end else begin : g_res_wn
            assign res_full = {cell_diff, res_q};
            for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_res_bit
                if (gi == WIDTH - 2) begin : g_top
                    assign res_shift[gi] = cell_diff;
                end else begin : g_mid
                    assign res_shift[gi] = res_q[gi+1];
                end
            end
        end
    endgenerate

    assign accept = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));

    always_comb begin
        state_d  = state_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        res_d    = res_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        bout_d   = bout_q;
        cnt_d    = cnt_q;

        case (state_q)
            S_IDLE: if (bus.start) state_d = S_RUN;
            S_RUN: begin
                sa_d     = sa_q >> 1;
                sb_d     = sb_q >> 1;
                res_d    = res_shift;
                borrow_d = cell_bout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    diff_d  = res_full;
                    bout_d  = cell_bout;
                end
            end
            S_DONE:  state_d = bus.start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            sa_d     = bus.a;
            sb_d     = bus.b;
            borrow_d = bus.bin;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sa_q     <= '0;
            sb_q     <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            bout_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            bout_q   <= bout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.busy = (state_q == S_RUN);
    assign bus.done = (state_q == S_DONE);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule
